// File: rtl/seq_multiplier_if.sv
// Start/busy/done handshake bundle for seq_multiplier.
// The sgn signal exists only when SEQ_MULT_SIGNED_EN is defined.
interface seq_multiplier_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
`ifdef SEQ_MULT_SIGNED_EN
  logic                 sgn;
`endif
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

`ifdef SEQ_MULT_SIGNED_EN
  modport master (output start, a, b, sgn, input busy, done, product);
  modport slave  (input start, a, b, sgn, output busy, done, product);
`else
  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
`endif
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier retiring one multiplier bit per clock.
// Define SEQ_MULT_SIGNED_EN to build two's-complement signed operation (sgn port).
module seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  seq_multiplier_if.slave bus
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mlt_q, mlt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PW-1:0]    prod_q, prod_d;

  logic [WIDTH:0]   sum;
  logic [PW:0]      shifted;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    prod_fin;

  // One add-and-shift step of the {accumulator, multiplier} pair
  always_comb begin
    sum     = acc_q + (mlt_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    shifted = {sum, mlt_q} >> 1;
  end

`ifdef SEQ_MULT_SIGNED_EN
  logic neg_q, neg_d;
  logic neg_in;

  // Magnitudes kept in WIDTH unsigned bits so the most negative operand is exact
  always_comb begin
    neg_in   = bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    a_mag    = (bus.sgn && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    b_mag    = (bus.sgn && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
    prod_fin = neg_q ? (~shifted[PW-1:0] + PW'(1)) : shifted[PW-1:0];
  end
`else
  always_comb begin
    a_mag    = bus.a;
    b_mag    = bus.b;
    prod_fin = shifted[PW-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      mlt_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mlt_q   <= mlt_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  // Next-state and next-register values; busy/done are registered copies of the next state
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mlt_d   = mlt_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    prod_d  = prod_q;
`ifdef SEQ_MULT_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = a_mag;
          mlt_d   = b_mag;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef SEQ_MULT_SIGNED_EN
          neg_d   = neg_in;
`endif
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = shifted[PW:WIDTH];
        mlt_d  = shifted[WIDTH-1:0];
        cnt_d  = cnt_q + CW'(1);
        busy_d = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          prod_d  = prod_fin;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = prod_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH 8, 2 and 32 against an a*b reference.
// Build with SEQ_MULT_SIGNED_EN defined to also exercise signed mode.
module tb_seq_multiplier;
`ifdef SEQ_MULT_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(8))  i8 ();
  seq_multiplier_if #(.WIDTH(2))  i2 ();
  seq_multiplier_if #(.WIDTH(32)) i32 ();

  seq_multiplier #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(i8));
  seq_multiplier #(.WIDTH(2))  u2  (.clk(clk), .rst(rst), .bus(i2));
  seq_multiplier #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(i32));

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp;
    string       nm;
  } vec_t;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endfunction

  // Reference: plain integer product of the operands read as W-bit values
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb;
    longint unsigned msk;
    msk = ~64'd0 >> (64 - 2 * w);
    sa  = longint'({32'd0, a}) & ((longint'(1) << w) - 1);
    sb  = longint'({32'd0, b}) & ((longint'(1) << w) - 1);
    if (s && sa[w-1]) sa = sa - (longint'(1) << w);
    if (s && sb[w-1]) sb = sb - (longint'(1) << w);
    return 64'(sa * sb) & msk;
  endfunction

  function automatic int width_of(input int sel);
    case (sel)
      0:       return 8;
      1:       return 2;
      default: return 32;
    endcase
  endfunction

  task automatic drive(input int sel, input logic st, input logic [31:0] a, input logic [31:0] b);
    case (sel)
      0:       begin i8.start  = st; i8.a  = 8'(a);  i8.b  = 8'(b);  end
      1:       begin i2.start  = st; i2.a  = 2'(a);  i2.b  = 2'(b);  end
      default: begin i32.start = st; i32.a = a;      i32.b = b;      end
    endcase
  endtask

`ifdef SEQ_MULT_SIGNED_EN
  task automatic set_sgn(input int sel, input logic s);
    case (sel)
      0:       i8.sgn  = s;
      1:       i2.sgn  = s;
      default: i32.sgn = s;
    endcase
  endtask
`endif

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return i8.done;
      1:       return i2.done;
      default: return i32.done;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return i8.busy;
      1:       return i2.busy;
      default: return i32.busy;
    endcase
  endfunction

  function automatic logic [63:0] get_prod(input int sel);
    case (sel)
      0:       return 64'(i8.product);
      1:       return 64'(i2.product);
      default: return 64'(i32.product);
    endcase
  endfunction

  // One-cycle start pulse, then check busy, latency and product
  task automatic op(input int sel, input logic [31:0] a, input logic [31:0] b, input logic s,
                    input logic [63:0] exp, input string nm);
    int w;
    int lat;
    w = width_of(sel);
    @(negedge clk);
    drive(sel, 1'b1, a, b);
`ifdef SEQ_MULT_SIGNED_EN
    set_sgn(sel, s);
`endif
    @(negedge clk);
    drive(sel, 1'b0, $urandom, $urandom);
`ifdef SEQ_MULT_SIGNED_EN
    set_sgn(sel, ~s);
`endif
    lat = 0;
    chk({nm, " busy"}, 64'(get_busy(sel)), 64'd1);
    while (!get_done(sel) && lat < w + 4) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(w));
    chk({nm, " product"}, get_prod(sel), exp);
  endtask

  initial begin
    vec_t vecs[$];
    int   d0, d1, ndone;
    logic [63:0] pdone;
    logic [31:0] ra, rb;
    logic        rs;

    vecs.push_back('{8'd13,  8'd11,  1'b0, 16'h008F, "u13x11"});
    vecs.push_back('{8'd255, 8'd255, 1'b0, 16'hFE01, "u255x255"});
    vecs.push_back('{8'd0,   8'd200, 1'b0, 16'h0000, "u0x200"});
    vecs.push_back('{8'hFD,  8'h05,  1'b0, 16'h04F1, "uFDx05"});
    vecs.push_back('{8'd1,   8'd255, 1'b0, 16'h00FF, "u1x255"});
`ifdef SEQ_MULT_SIGNED_EN
    vecs.push_back('{8'h80,  8'h80,  1'b1, 16'h4000, "s80x80"});
    vecs.push_back('{8'hFD,  8'h05,  1'b1, 16'hFFF1, "sFDx05"});
    vecs.push_back('{8'h7F,  8'h80,  1'b1, 16'hC080, "s7Fx80"});
    vecs.push_back('{8'hFF,  8'hFF,  1'b1, 16'h0001, "sFFxFF"});
`endif

    for (int s = 0; s < 3; s++) drive(s, 1'b0, 32'd0, 32'd0);
`ifdef SEQ_MULT_SIGNED_EN
    for (int s = 0; s < 3; s++) set_sgn(s, 1'b0);
`endif

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset busy w%0d", width_of(s)), 64'(get_busy(s)), 64'd0);
      chk($sformatf("reset done w%0d", width_of(s)), 64'(get_done(s)), 64'd0);
      chk($sformatf("reset product w%0d", width_of(s)), get_prod(s), 64'd0);
    end

    foreach (vecs[i]) op(0, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].s, 64'(vecs[i].exp), vecs[i].nm);

    // Start pulsed while busy is ignored; product then holds
    @(negedge clk);
    drive(0, 1'b1, 32'd13, 32'd11);
`ifdef SEQ_MULT_SIGNED_EN
    set_sgn(0, 1'b0);
`endif
    ndone = 0;
    pdone = '0;
    for (int k = 0; k < 3 * 8; k++) begin
      @(negedge clk);
      drive(0, (k == 2), (k == 2) ? 32'd3 : 32'd0, (k == 2) ? 32'd4 : 32'd0);
      if (i8.done) begin
        ndone++;
        pdone = 64'(i8.product);
      end
    end
    chk("busy-start done count", 64'(ndone), 64'd1);
    chk("busy-start product", pdone, 64'h008F);
    chk("product holds", 64'(i8.product), 64'h008F);
    chk("done idle low", 64'(i8.done), 64'd0);

    // Start held high: accepts spaced WIDTH+2 apart
    @(negedge clk);
    drive(0, 1'b1, 32'd13, 32'd11);
    d0 = -1;
    d1 = -1;
    for (int k = 0; k < 3 * 10; k++) begin
      @(negedge clk);
      if (i8.done) begin
        if (d0 < 0) d0 = k;
        else if (d1 < 0) d1 = k;
        chk("held-start product", 64'(i8.product), 64'h008F);
      end
    end
    drive(0, 1'b0, 32'd0, 32'd0);
    chk("held-start first latency", 64'(d0), 64'd8);
    chk("held-start interval", 64'(d1 - d0), 64'd10);
    repeat (24) @(negedge clk);

    // Reset mid-run discards the operation
    op(0, 32'd255, 32'd255, 1'b0, 64'hFE01, "pre-reset");
    @(negedge clk);
    drive(0, 1'b1, 32'd255, 32'd255);
    @(negedge clk);
    drive(0, 1'b0, 32'd0, 32'd0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun-reset busy", 64'(i8.busy), 64'd0);
    chk("midrun-reset done", 64'(i8.done), 64'd0);
    chk("midrun-reset product", 64'(i8.product), 64'd0);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (i8.done) ndone++;
    end
    chk("midrun-reset no done", 64'(ndone), 64'd0);
    op(0, 32'd2, 32'd3, 1'b0, 64'd6, "post-reset 2x3");

    // WIDTH=8 random
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom) & SIGNED_BUILD;
      op(0, ra, rb, rs, ref_mul(8, ra, rb, rs), $sformatf("w8 rnd %0d", i));
    end

    // WIDTH=2 exhaustive
    for (int s = 0; s <= int'(SIGNED_BUILD); s++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++)
          op(1, 32'(a), 32'(b), 1'(s), ref_mul(2, 32'(a), 32'(b), 1'(s)),
             $sformatf("w2 s%0d %0dx%0d", s, a, b));

    // WIDTH=32 random plus extremes
    op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, ref_mul(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0), "w32 max");
    op(2, 32'h8000_0000, 32'h8000_0000, SIGNED_BUILD,
       ref_mul(32, 32'h8000_0000, 32'h8000_0000, SIGNED_BUILD), "w32 minneg");
    for (int i = 0; i < 500; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom) & SIGNED_BUILD;
      op(2, ra, rb, rs, ref_mul(32, ra, rb, rs), $sformatf("w32 rnd %0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
